// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared types and helpers for the arithmetic cell library
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Bits needed for a counter that runs 0..w-1; never less than one bit.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - one-bit full adder built from two half-adder stages and an OR
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;
  logic g_ab;
  logic g_pc;

  assign p    = a ^ b;
  assign g_ab = a & b;
  assign s    = p ^ ci;
  assign g_pc = p & ci;
  assign co   = g_ab | g_pc;

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder with carry-out and signed overflow
module serial_adder
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_q;
  state_t           state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_next;
  logic             carry_q;
  logic             a_msb_q;
  logic             b_msb_q;
  logic             fa_s;
  logic             fa_co;
  logic             accept;
  logic             last_step;

  full_adder u_cell (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  assign accept    = start && (state_q != SHIFT);
  assign last_step = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));
  // New bit enters at the MSB; after WIDTH steps bit 0 has reached position 0.
  assign r_next    = {fa_s, {(WIDTH-1){1'b0}}} | (r_sh >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_step) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = start ? SHIFT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      r_sh     <= '0;
      carry_q  <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      cnt_q   <= '0;
      a_sh    <= a;
      b_sh    <= b;
      carry_q <= cin;
      a_msb_q <= a[WIDTH-1];
      b_msb_q <= b[WIDTH-1];
    end else if (state_q == SHIFT) begin
      cnt_q   <= cnt_q + CW'(1);
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      r_sh    <= r_next;
      carry_q <= fa_co;
      // Results are published only here so they never expose partial sums.
      if (last_step) begin
        sum      <= r_next;
        cout     <= fa_co;
        overflow <= (a_msb_q == b_msb_q) && (fa_s != a_msb_q);
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder against a behavioural model
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an operation is a pending a+b+cin that appears WIDTH clocks after accept.
  logic             m_busy = 1'b0;
  logic             m_done = 1'b0;
  int               m_left = 0;
  logic [WIDTH-1:0] m_sum = '0;
  logic             m_cout = 1'b0;
  logic             m_ovf = 1'b0;
  logic [WIDTH:0]   p_res = '0;
  logic             p_ovf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_left = 0;
      m_sum  = '0;
      m_cout = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          {m_cout, m_sum} = p_res;
          m_ovf = p_ovf;
        end
      end else if (start) begin
        int sa, sb, ss;
        m_busy = 1'b1;
        m_left = WIDTH;
        p_res  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        sa = $signed(a);
        sb = $signed(b);
        ss = sa + sb + int'(cin);
        p_ovf = (ss > (2 ** (WIDTH - 1)) - 1) || (ss < -(2 ** (WIDTH - 1)));
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("sum", sum, m_sum);
    chk("cout", cout, m_cout);
    chk("overflow", overflow, m_ovf);
    if (done) done_cnt++;
  end

  task automatic issue(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v, input logic tc);
    start = 1'b1;
    a     = ta;
    b     = tb_v;
    cin   = tc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int n0, output int n);
    n = n0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done && n < 40);
    chk("done_seen", done, 1'b1);
  endtask

  task automatic run_op(input string name, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                        input logic tc, input logic [WIDTH-1:0] esum, input logic ecout, input logic eovf);
    int n;
    issue(ta, tb_v, tc);
    wait_done(0, n);
    chk({name, "_latency"}, n, WIDTH);
    chk({name, "_sum"}, sum, esum);
    chk({name, "_cout"}, cout, ecout);
    chk({name, "_ovf"}, overflow, eovf);
  endtask

  initial begin
    int n;
    int saved;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sum", sum, 8'h00);
    chk("rst_cout", cout, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run_op("t35_4a", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
    run_op("tff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("tff_ff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_op("t7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("t80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // Starts during the busy window must neither queue nor corrupt the operation.
    saved = done_cnt;
    issue(8'h10, 8'h20, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; a = 8'hAA; b = 8'h55;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(4, n);
    chk("ign_latency", n, WIDTH);
    chk("ign_sum", sum, 8'h30);

    // Back-to-back start in the done cycle; previous result must hold until the final edge.
    issue(8'h01, 8'h02, 1'b0);
    for (int i = 1; i < WIDTH; i++) begin
      @(posedge clk); #1;
    end
    chk("hold_sum", sum, 8'h30);
    chk("hold_done", done, 1'b0);
    wait_done(WIDTH - 1, n);
    chk("b2b_latency", n, WIDTH);
    chk("b2b_sum", sum, 8'h03);
    chk("ign_single_done", done_cnt, saved + 1);

    // Mid-operation reset aborts immediately and suppresses done.
    issue(8'h55, 8'h66, 1'b0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    saved = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_sum", sum, 8'h00);
    chk("abort_cout", cout, 1'b0);
    chk("abort_ovf", overflow, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("abort_no_done", done_cnt, saved + 1 - 1);
    run_op("t0f_f1", 8'h0F, 8'hF1, 1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic: inputs change every cycle, start asserted at random.
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      a     = WIDTH'($urandom);
      b     = WIDTH'($urandom);
      cin   = 1'($urandom);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    repeat (WIDTH + 4) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
